// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch controller.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } ifu_state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam int          IM_AW       = 5;
  localparam int          IM_DEPTH    = 1 << IM_AW;
  localparam int          IFU_N       = 32;

endpackage

// File: rtl/ifu_ctrl.sv
// Fetch controller: walks a word-addressed instruction memory and presents
// one instruction at a time through a valid/ready output register.
module ifu_ctrl
  import ifu_pkg::*;
#(
  parameter int N  = IFU_N,
  parameter int AW = IM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic [AW-1:0] addressIM,
  input  logic [N-1:0]  inst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_inst,
  output logic [N-1:0]  out_pc,
  output logic [1:0]    state_o,
  output logic          fault,
  output logic [15:0]   fetch_cnt
);

  ifu_state_e  state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_inst_q, out_inst_d;
  logic [N-1:0] out_pc_q, out_pc_d;
  logic [15:0]  fetch_cnt_q, fetch_cnt_d;

  logic handshake;
  logic can_load;
  logic pc_out_of_range;
  logic redirect_misaligned;

  assign handshake           = out_valid_q && out_ready;
  assign can_load            = !out_valid_q || handshake;
  assign pc_out_of_range     = (pc_q >> (AW + 2)) != '0;
  assign redirect_misaligned = redirect_pc[1:0] != 2'b00;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    fetch_cnt_d = fetch_cnt_q;

    if (state_q == ST_FAULT) begin
      out_valid_d = 1'b0;
    end else if (redirect_valid) begin
      // A redirect flushes the output register; a coincident handshake is
      // treated as accepted, so nothing is lost by dropping out_valid.
      out_valid_d = 1'b0;
      if (redirect_misaligned) state_d = ST_FAULT;
      else                     pc_d    = redirect_pc;
    end else if (state_q == ST_RUN) begin
      if (can_load) begin
        if (pc_out_of_range) begin
          state_d     = ST_FAULT;
          out_valid_d = 1'b0;
        end else begin
          out_inst_d  = inst;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + N'(4);
          if (fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
          if (inst == N'(EBREAK_INST)) state_d = ST_HALT;
        end
      end
    end else begin
      // IDLE/HALT: no loads, but a pending instruction still drains.
      if (handshake) out_valid_d = 1'b0;
      if (start)     state_d     = ST_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign addressIM = pc_q[AW+1:2];
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;
  assign state_o   = state_q;
  assign fault     = (state_q == ST_FAULT);
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_ctrl.sv
// Self-checking bench for ifu_ctrl: directed scenarios plus a randomized
// phase, all compared cycle by cycle against a behavioural fetch model.
module tb_ifu_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  addressIM;
  logic [31:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  state_o;
  logic        fault;
  logic [15:0] fetch_cnt;

  logic [31:0] im [32];

  int total = 0;
  int bad   = 0;

  // Behavioural model: 0=idle 1=run 2=halt 3=fault
  int          m_state;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_out_pc;
  int          m_cnt;

  always #5 clk = ~clk;

  assign inst = im[addressIM];

  ifu_ctrl #(.N(32), .AW(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .addressIM      (addressIM),
    .inst           (inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .state_o        (state_o),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_valid = 0; m_inst = 0; m_out_pc = 0; m_cnt = 0;
  endtask

  // One clock of the fetch rules, applied to the inputs currently driven.
  task automatic model_step();
    bit hs;
    logic [31:0] w;
    hs = m_valid && out_ready;
    if (m_state == 3) begin
      m_valid = 0;
    end else if (redirect_valid) begin
      m_valid = 0;
      if (redirect_pc % 4 != 0) m_state = 3;
      else                      m_pc = redirect_pc;
    end else if (m_state == 1) begin
      if (!m_valid || hs) begin
        if (m_pc >= 32'd128) begin
          m_state = 3;
          m_valid = 0;
        end else begin
          w        = im[m_pc / 4];
          m_inst   = w;
          m_out_pc = m_pc;
          m_valid  = 1;
          m_pc     = m_pc + 32'd4;
          if (m_cnt < 65535) m_cnt++;
          if (w == EBREAK) m_state = 2;
        end
      end
    end else begin
      if (hs) m_valid = 0;
      if (start) m_state = 1;
    end
  endtask

  task automatic check_model();
    check("m_state", 32'(state_o), 32'(m_state));
    check("m_valid", 32'(out_valid), 32'(m_valid));
    check("m_fault", 32'(fault), 32'(m_state == 3));
    check("m_addr", 32'(addressIM), (m_pc / 4) % 32);
    check("m_cnt", 32'(fetch_cnt), 32'(m_cnt));
    if (m_valid) begin
      check("m_out_pc", out_pc, m_out_pc);
      check("m_out_inst", out_inst, m_inst);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Asserts reset between clock edges and checks outputs clear before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    model_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pc", out_pc, 0);
    check("rst_inst", out_inst, 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_cnt", 32'(fetch_cnt), 0);
    check("rst_addr", 32'(addressIM), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_seq_im();
    for (int i = 0; i < 32; i++) im[i] = 32'hA5A5_0000 + 32'(i * 17 + 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    load_seq_im();
    #3;
    do_reset();

    // Sequential streaming at one instruction per clock.
    pulse_start();
    check("run_state", 32'(state_o), 1);
    check("run_novalid", 32'(out_valid), 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("seq_pc", out_pc, 32'(k * 4));
      check("seq_inst", out_inst, im[k]);
      check("seq_cnt", 32'(fetch_cnt), 32'(k + 1));
    end

    // Stall while out_pc = 8.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_pc", out_pc, 32'h8);
      check("stall_inst", out_inst, im[2]);
      check("stall_addr", 32'(addressIM), 3);
      check("stall_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    cycle();
    check("resume_pc", out_pc, 32'hC);

    // Redirect while stalled.
    out_ready = 1'b0;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(out_valid), 0);
    check("redir_addr", 32'(addressIM), 16);
    out_ready = 1'b1;
    cycle();
    check("redir_pc", out_pc, 32'h40);
    check("redir_inst", out_inst, im[16]);

    // Async reset mid-run, then no load without start.
    @(posedge clk); #3;
    do_reset();
    cycle();
    cycle();
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_state", 32'(state_o), 0);

    // EBREAK at word 3, resume, then run off the end of the memory.
    im[3] = EBREAK;
    pulse_start();
    for (int k = 0; k < 4; k++) cycle();
    check("halt_pc", out_pc, 32'hC);
    check("halt_state", 32'(state_o), 2);
    check("halt_valid", 32'(out_valid), 1);
    cycle();
    cycle();
    check("halt_drain", 32'(out_valid), 0);
    check("halt_cnt", 32'(fetch_cnt), 4);
    pulse_start();
    cycle();
    check("resume16_pc", out_pc, 32'h10);
    begin
      int budget = 40;
      while (out_pc !== 32'h7C && budget > 0) begin
        cycle();
        budget--;
      end
      check("reach_7c", out_pc, 32'h7C);
    end
    cycle();
    check("range_state", 32'(state_o), 3);
    check("range_fault", 32'(fault), 1);
    check("range_valid", 32'(out_valid), 0);
    pulse_start();
    check("fault_sticky", 32'(state_o), 3);

    // Misaligned redirect.
    @(posedge clk); #3;
    do_reset();
    load_seq_im();
    pulse_start();
    cycle();
    cycle();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    cycle();
    redirect_valid = 1'b0;
    check("mis_fault", 32'(fault), 1);
    check("mis_state", 32'(state_o), 3);
    check("mis_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    pulse_start();
    cycle();
    check("mis_start_ign", 32'(state_o), 3);

    // Randomized traffic against the model.
    @(posedge clk); #3;
    do_reset();
    for (int i = 0; i < 32; i++) im[i] = ($urandom_range(0, 15) == 0) ? EBREAK : $urandom;
    for (int i = 0; i < 600; i++) begin
      int r;
      start     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      redirect_valid = (r < 8);
      r = $urandom_range(0, 99);
      if (r < 10)      redirect_pc = 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(1, 3));
      else if (r < 20) redirect_pc = 32'h80 + 32'($urandom_range(0, 15) << 2);
      else             redirect_pc = 32'($urandom_range(0, 31) << 2);
      cycle();
      if (m_state == 3 && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #3;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_ctrl.md
IFU_CTRL -- requirements
Module: ifu_ctrl

Interface
REQ-001 Parameter N, default 32, instruction and PC width.
REQ-002 Parameter AW, default 5, IM word-address width (32 words).
REQ-003 clk  in  1  rising-edge clock; the block's only clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle pulse; leaves IDLE or HALT to RUN.
REQ-006 redirect_valid  in  1  PC redirect request (branch/jump).
REQ-007 redirect_pc  in  N  byte address of redirect target.
REQ-008 addressIM  out  AW  word index driven to the instruction memory.
REQ-009 inst  in  N  IM read data, combinational from addressIM.
REQ-010 out_valid  out  1  out_inst/out_pc hold a fetched instruction.
REQ-011 out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-012 out_inst  out  N  fetched instruction word.
REQ-013 out_pc  out  N  byte address of out_inst.
REQ-014 state_o  out  2  current state (IDLE=0, RUN=1, HALT=2, FAULT=3).
REQ-015 fault  out  1  sticky error flag, high in FAULT.
REQ-016 fetch_cnt  out  16  count of instructions loaded into output register.

Function
REQ-017 Internal pc register (N bits, byte address); addressIM SHALL equal pc[AW+1:2] in every state.
REQ-018 States SHALL be IDLE, RUN, HALT, FAULT; IDLE->RUN on start; HALT->RUN on start, resuming at current pc.
REQ-019 In RUN, a load SHALL occur when output register is empty or handshake completes this cycle, and no redirect is present.
REQ-020 On load: out_inst<=inst, out_pc<=pc, out_valid<=1, pc<=pc+4 (mod 2^N), fetch_cnt+=1 saturating at 0xFFFF.
REQ-021 Latency: instruction at pc SHALL appear on out_valid one clock after pc is presented; sustained throughput one instruction per clock while out_ready=1.
REQ-022 Stall: out_valid && !out_ready SHALL hold out_inst, out_pc, out_valid and pc unchanged.
REQ-023 Without handshake or redirect, out_valid SHALL only fall when its content is accepted and no new load occurs.
REQ-024 Redirect has highest priority in IDLE, RUN, HALT: pc<=redirect_pc, out_valid<=0 next cycle, no load that cycle.
REQ-025 Redirect coincident with handshake: handshake counts as completed; out_valid low next cycle.
REQ-026 Redirect with redirect_pc[1:0]!=0 SHALL enter FAULT instead of updating pc.
REQ-027 Redirect in IDLE/HALT SHALL update pc without changing state.
REQ-028 Out of range: in RUN, if pc[N-1:AW+2]!=0 when a load would occur, enter FAULT without loading.
REQ-029 Halt: a load with inst==32'h00100073 (EBREAK) SHALL load normally and transition to HALT; no further loads in HALT.
REQ-030 In HALT the output register drains via normal handshake.
REQ-031 FAULT: out_valid<=0, fault=1, all inputs ignored, exit only by reset.
REQ-032 start in RUN or FAULT SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, pc 0, out_valid 0, out_inst 0, out_pc 0, fault 0, fetch_cnt 0.
REQ-034 Reset mid-operation SHALL discard any pending instruction; first load after release requires start.

Structure
REQ-035 Package ifu_pkg SHALL hold state enum, EBREAK constant, IM depth/AW defaults.
REQ-036 Single flat module; no sub-module; IM instantiated outside and wired via addressIM/inst.

Verification
REQ-037 IM = words 0..7 distinct, out_ready=1, start pulse -> out_pc 0,4,8,... on consecutive cycles, fetch_cnt increments per cycle.
REQ-038 out_ready low 3 cycles while out_pc=8 -> out_pc/out_inst/addressIM stable; resumes with 12 after ready.
REQ-039 redirect_pc=0x40 while out_valid && !out_ready -> out_valid 0 next cycle, then out_pc=0x40, addressIM=16.
REQ-040 redirect_pc=0x42 -> fault=1, state_o=3, out_valid 0, start ignored until rst_n low.
REQ-041 EBREAK at word 3 -> out_pc 12 delivered, state_o=2, no further loads; start -> out_pc 16 next.
REQ-042 Sequential run past pc=0x7C -> FAULT at pc=0x80; rst_n asserted mid-RUN -> all outputs zero asynchronously.
